pipeline_hazard_ctrl: RTL

//  Sequences the fetch->decode->reg-fetch->execute pipeline registers. Drives their enable and flush controls.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 17 +
 rtl/pipeline_hazard_ctrl_src_match.sv | 39 +++
 rtl/pipeline_hazard_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Imported by pipeline_hazard_ctrl and hazard_src_match.
package hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_MEM_WAIT = 2'd2
   } hz_state_t;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [3:0] REG_PC  = 4'd15;

endpackage

// File: rtl/pipeline_hazard_ctrl_src_match.sv
// Compare/select logic for one decode source operand against the EX and MEM producers.
// R15 is the PC: it never matches, so branch writes are never forwarded.
module hazard_src_match
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 4
) (
   input  logic [REG_ADDR_W-1:0] src,
   input  logic                  src_used,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_wr,
   input  logic                  ex_is_load,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  mem_wr,
   output logic [1:0]            fwd_sel,
   output logic                  ex_load_hit,
   output logic                  any_hit
);

   logic live;
   logic ex_hit;
   logic mem_hit;

   assign live        = src_used && (src != REG_ADDR_W'(REG_PC));
   assign ex_hit      = live && ex_wr && (ex_rd == src);
   assign mem_hit     = live && mem_wr && (mem_rd == src);
   assign ex_load_hit = ex_hit && ex_is_load;
   assign any_hit     = ex_hit || mem_hit;

   // A load result is not available in EX, so only an ALU producer forwards from EX.
   always_comb begin
      fwd_sel = FWD_REG;
      if (ex_hit && !ex_is_load)
         fwd_sel = FWD_EX;
      else if (mem_hit)
         fwd_sel = FWD_MEM;
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencing: enables, flushes, stalls and operand forwarding selects.
// Build option HAZARD_FWD_EN: enables EX/MEM forwarding; without it every RAW match stalls.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_RUN      | normal issue; branch flush start and load-use/RAW stalls
// ST_FLUSH    | killing fetch/decode after a taken branch, flush_left to go
// ST_MEM_WAIT | data memory busy, whole pipe frozen; ret_state resumes
module pipeline_hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W   = 4,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rn,
   input  logic [REG_ADDR_W-1:0] id_rm,
   input  logic                  id_use_rn,
   input  logic                  id_use_rm,
   input  logic                  ex_valid,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_wr,
   input  logic                  ex_is_load,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  mem_wr,
   input  logic                  br_taken,
   input  logic                  mem_busy,
   output logic                  pc_en,
   output logic                  fd_en,
   output logic                  fd_flush,
   output logic                  de_en,
   output logic                  de_bubble,
   output logic                  em_en,
   output logic [1:0]            fwd_a_sel,
   output logic [1:0]            fwd_b_sel,
   output logic [CNT_W-1:0]      stall_cnt
);

   localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   hz_state_t       state, state_n;
   hz_state_t       ret_state, ret_state_n;
   hz_state_t       eff_state;
   logic [FL_W-1:0] flush_left, flush_left_n;

   logic [1:0] sel_a, sel_b;
   logic       lu_a, lu_b;
   logic       hit_a, hit_b;
   logic       hazard;
   logic [1:0] fwd_a_raw, fwd_b_raw;
   logic       unused_ok;

   hazard_src_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_rn (
      .src         (id_rn),
      .src_used    (id_use_rn),
      .ex_rd       (ex_rd),
      .ex_wr       (ex_wr),
      .ex_is_load  (ex_is_load),
      .mem_rd      (mem_rd),
      .mem_wr      (mem_wr),
      .fwd_sel     (sel_a),
      .ex_load_hit (lu_a),
      .any_hit     (hit_a)
   );

   hazard_src_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_rm (
      .src         (id_rm),
      .src_used    (id_use_rm),
      .ex_rd       (ex_rd),
      .ex_wr       (ex_wr),
      .ex_is_load  (ex_is_load),
      .mem_rd      (mem_rd),
      .mem_wr      (mem_wr),
      .fwd_sel     (sel_b),
      .ex_load_hit (lu_b),
      .any_hit     (hit_b)
   );

`ifdef HAZARD_FWD_EN
   assign hazard    = id_valid && ex_valid && (lu_a || lu_b);
   assign fwd_a_raw = sel_a;
   assign fwd_b_raw = sel_b;
   assign unused_ok = &{1'b0, hit_a, hit_b};
`else
   // No bypass paths: hold decode until the producer has retired from MEM.
   assign hazard    = id_valid && (hit_a || hit_b);
   assign fwd_a_raw = FWD_REG;
   assign fwd_b_raw = FWD_REG;
   assign unused_ok = &{1'b0, lu_a, lu_b, sel_a, sel_b};
`endif

   // Leaving MEM_WAIT happens in the same cycle mem_busy drops, so decode from the saved state.
   assign eff_state = (state == ST_MEM_WAIT) ? ret_state : state;

   always_comb begin
      pc_en        = 1'b1;
      fd_en        = 1'b1;
      fd_flush     = 1'b0;
      de_en        = 1'b1;
      de_bubble    = 1'b0;
      em_en        = 1'b1;
      fwd_a_sel    = fwd_a_raw;
      fwd_b_sel    = fwd_b_raw;
      state_n      = state;
      ret_state_n  = ret_state;
      flush_left_n = flush_left;

      if (reset) begin
         pc_en        = 1'b0;
         fd_en        = 1'b0;
         fd_flush     = 1'b1;
         de_en        = 1'b0;
         de_bubble    = 1'b1;
         em_en        = 1'b0;
         fwd_a_sel    = FWD_REG;
         fwd_b_sel    = FWD_REG;
         state_n      = ST_RUN;
         ret_state_n  = ST_RUN;
         flush_left_n = '0;
      end else if (mem_busy) begin
         pc_en       = 1'b0;
         fd_en       = 1'b0;
         de_en       = 1'b0;
         em_en       = 1'b0;
         state_n     = ST_MEM_WAIT;
         ret_state_n = eff_state;
      end else begin
         case (eff_state)
            ST_FLUSH: begin
               fd_flush     = 1'b1;
               de_bubble    = 1'b1;
               flush_left_n = flush_left - 1'b1;
               state_n      = (flush_left_n == '0) ? ST_RUN : ST_FLUSH;
            end
            default: begin
               state_n = ST_RUN;
               if (br_taken && ex_valid) begin
                  fd_flush  = 1'b1;
                  de_bubble = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     state_n      = ST_FLUSH;
                     flush_left_n = FL_W'(FLUSH_CYCLES - 1);
                  end
               end else if (hazard) begin
                  pc_en     = 1'b0;
                  fd_en     = 1'b0;
                  de_bubble = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_RUN;
         ret_state  <= ST_RUN;
         flush_left <= '0;
         stall_cnt  <= '0;
      end else begin
         state      <= state_n;
         ret_state  <= ret_state_n;
         flush_left <= flush_left_n;
         if (!pc_en && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule
